// File: rtl/alu_arbiter.sv
// Two-requester valid/ready arbiter in front of one shared combinational ALU.
// Defining ALU_ARB_FIXED_PRIO_EN gives requester 0 fixed priority; otherwise round-robin.
module alu_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ALU_CTRL_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [DATA_WIDTH-1:0]     req0_src_a,
   input  logic [DATA_WIDTH-1:0]     req1_src_a,
   input  logic [DATA_WIDTH-1:0]     req0_src_b,
   input  logic [DATA_WIDTH-1:0]     req1_src_b,
   input  logic [ALU_CTRL_WIDTH-1:0] req0_ctrl,
   input  logic [ALU_CTRL_WIDTH-1:0] req1_ctrl,
   output logic [DATA_WIDTH-1:0]     alu_src_a,
   output logic [DATA_WIDTH-1:0]     alu_src_b,
   output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
   input  logic [DATA_WIDTH-1:0]     alu_result,
   input  logic                      alu_zero,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_result,
   output logic                      rsp_zero,
   output logic                      rsp_id
);

   logic                  rsp_valid_q,  rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic                  rsp_zero_q,   rsp_zero_d;
   logic                  rsp_id_q,     rsp_id_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic                  last_grant_q, last_grant_d;
`endif

   logic       can_accept;
   logic [1:0] grant;
   logic       xfer;
   logic       xfer_id;

   // The entry can take a new result if it is empty or being drained this cycle.
   assign can_accept = !rsp_valid_q || rsp_ready;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant = 2'b00;
      if (can_accept) begin
         case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
            2'b11:   grant = 2'b01;
`else
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
`endif
            default: grant = 2'b00;
         endcase
      end
   end

   assign req_ready = grant;
   assign xfer      = |grant;
   assign xfer_id   = grant[1];

   // Idle drive is 0 + 0 with the add code, keeping the ALU inputs quiet.
   always_comb begin
      alu_src_a = '0;
      alu_src_b = '0;
      alu_ctrl  = '0;
      if (grant[0]) begin
         alu_src_a = req0_src_a;
         alu_src_b = req0_src_b;
         alu_ctrl  = req0_ctrl;
      end else if (grant[1]) begin
         alu_src_a = req1_src_a;
         alu_src_b = req1_src_b;
         alu_ctrl  = req1_ctrl;
      end
   end

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_id_d     = rsp_id_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      if (xfer) begin
         rsp_valid_d  = 1'b1;
         rsp_result_d = alu_result;
         rsp_zero_d   = alu_zero;
         rsp_id_d     = xfer_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_grant_d = xfer_id;
`endif
      end else if (rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_id_q     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         // Starting at 1 lets requester 0 win the first contention.
         last_grant_q <= 1'b1;
`endif
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_id_q     <= rsp_id_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes hand-computed responses,
// a negedge monitor pops and compares each response as it drains.
module tb_alu_arbiter;

   localparam int DW = 32;
   localparam int CW = 4;

   typedef struct packed {
      logic [DW-1:0] result;
      logic          zero;
      logic          id;
   } rsp_t;

   logic          clk;
   logic          rst;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [DW-1:0] req0_src_a, req1_src_a, req0_src_b, req1_src_b;
   logic [CW-1:0] req0_ctrl, req1_ctrl;
   logic [DW-1:0] alu_src_a, alu_src_b;
   logic [CW-1:0] alu_ctrl;
   logic [DW-1:0] alu_result;
   logic          alu_zero;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_result;
   logic          rsp_zero;
   logic          rsp_id;

   rsp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   alu_arbiter #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req0_src_a (req0_src_a),
      .req1_src_a (req1_src_a),
      .req0_src_b (req0_src_b),
      .req1_src_b (req1_src_b),
      .req0_ctrl  (req0_ctrl),
      .req1_ctrl  (req1_ctrl),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_id     (rsp_id)
   );

   // Simple shared ALU: add, sub, and, or; anything else adds.
   always_comb begin
      case (alu_ctrl)
         4'b0001: alu_result = alu_src_a - alu_src_b;
         4'b0010: alu_result = alu_src_a & alu_src_b;
         4'b0011: alu_result = alu_src_a | alu_src_b;
         default: alu_result = alu_src_a + alu_src_b;
      endcase
      alu_zero = (alu_result == '0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] r, input logic z, input logic id);
      rsp_t e;
      e.result = r;
      e.zero   = z;
      e.id     = id;
      exp_q.push_back(e);
   endtask

   // Monitor: a response is consumed on the edge after a negedge that sees valid & ready.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("sb_result", rsp_result, e.result);
            check("sb_zero",   {31'd0, rsp_zero}, {31'd0, e.zero});
            check("sb_id",     {31'd0, rsp_id},   {31'd0, e.id});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
      req0_src_a = '0; req0_src_b = '0; req0_ctrl = '0;
      req1_src_a = '0; req1_src_b = '0; req1_ctrl = '0;
      step(); step();
      rst = 1'b0;
      #3;
      check("reset_valid",  {31'd0, rsp_valid}, 32'd0);
      check("reset_result", rsp_result, 32'd0);
      check("reset_zero",   {31'd0, rsp_zero}, 32'd0);
      check("reset_id",     {31'd0, rsp_id}, 32'd0);
      step();

      // req0 only: 7 + 5
      req0_src_a = 32'd7; req0_src_b = 32'd5; req0_ctrl = 4'b0000; req_valid = 2'b01;
      #3 check("r0_ready", {30'd0, req_ready}, 32'd1);
      push(32'd12, 1'b0, 1'b0);
      step(); req_valid = 2'b00;
      #3 check("r0_latency", {31'd0, rsp_valid}, 32'd1);
      step();

      // req1 only: 5 - 5 -> zero
      req1_src_a = 32'd5; req1_src_b = 32'd5; req1_ctrl = 4'b0001; req_valid = 2'b10;
      #3 check("r1_ready", {30'd0, req_ready}, 32'd2);
      push(32'd0, 1'b1, 1'b1);
      step(); req_valid = 2'b00;
      #3 check("r1_latency", {31'd0, rsp_valid}, 32'd1);
      step();

      // Contention for 4 cycles: req0 10+3=13, req1 9-4=5
      req0_src_a = 32'd10; req0_src_b = 32'd3; req0_ctrl = 4'b0000;
      req1_src_a = 32'd9;  req1_src_b = 32'd4; req1_ctrl = 4'b0001;
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         logic g1;
`ifdef ALU_ARB_FIXED_PRIO_EN
         g1 = 1'b0;
`else
         g1 = (i % 2) == 1;
`endif
         #3;
         check("rr_ready", {30'd0, req_ready}, g1 ? 32'd2 : 32'd1);
         if (i > 0) check("rr_b2b_valid", {31'd0, rsp_valid}, 32'd1);
         push(g1 ? 32'd5 : 32'd13, 1'b0, g1);
         step();
      end
      req_valid = 2'b00;
      #3 check("rr_last_valid", {31'd0, rsp_valid}, 32'd1);
      step();

      // Backpressure: fill with 1|2=3, then hold while req0 offers 6&3=2
      req0_src_a = 32'd1; req0_src_b = 32'd2; req0_ctrl = 4'b0011; req_valid = 2'b01;
      #3 check("bp_fill_ready", {30'd0, req_ready}, 32'd1);
      push(32'd3, 1'b0, 1'b0);
      step();
      rsp_ready = 1'b0;
      req0_src_a = 32'd6; req0_src_b = 32'd3; req0_ctrl = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         #3;
         check("bp_ready", {30'd0, req_ready}, 32'd0);
         check("bp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_result_stable", rsp_result, 32'd3);
         step();
      end
      rsp_ready = 1'b1;
      #3 check("bp_release_ready", {30'd0, req_ready}, 32'd1);
      push(32'd2, 1'b0, 1'b0);
      step(); req_valid = 2'b00;
      #3 check("bp_new_result", rsp_result, 32'd2);
      step();
      #3 check("drain_valid", {31'd0, rsp_valid}, 32'd0);

      // Reset while holding 0-1 = FFFFFFFF from requester 1
      rsp_ready = 1'b0;
      req1_src_a = 32'd0; req1_src_b = 32'd1; req1_ctrl = 4'b0001; req_valid = 2'b10;
      step(); req_valid = 2'b00;
      #3;
      check("pre_rst_result", rsp_result, 32'hFFFF_FFFF);
      check("pre_rst_id", {31'd0, rsp_id}, 32'd1);
      rst = 1'b1;
      step(); rst = 1'b0;
      #3;
      check("rst_valid",  {31'd0, rsp_valid}, 32'd0);
      check("rst_result", rsp_result, 32'd0);
      check("rst_id",     {31'd0, rsp_id}, 32'd0);

      // Leave last grant on requester 0, reset, then contention must still favour 0
      req0_src_a = 32'd2; req0_src_b = 32'd2; req0_ctrl = 4'b0001; req_valid = 2'b01;
      step(); req_valid = 2'b00;
      rst = 1'b1;
      step(); rst = 1'b0;
      rsp_ready = 1'b1;
      req0_src_a = 32'd20; req0_src_b = 32'd22; req0_ctrl = 4'b0000;
      req1_src_a = 32'd1;  req1_src_b = 32'd1;  req1_ctrl = 4'b0000;
      req_valid = 2'b11;
      #3 check("post_rst_grant", {30'd0, req_ready}, 32'd1);
      push(32'd42, 1'b0, 1'b0);
      step(); req_valid = 2'b00;

      // Idle: ALU inputs parked even though requester operands are nonzero
      #3;
      check("idle_src_a", alu_src_a, 32'd0);
      check("idle_src_b", alu_src_b, 32'd0);
      check("idle_ctrl",  {28'd0, alu_ctrl}, 32'd0);
      step();
      #3 check("idle_valid_fall", {31'd0, rsp_valid}, 32'd0);
      step(); step();
      check("sb_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
